// File: rtl/sb_trans_gen_param.sv
// Sideband transaction generator.
// Serialises AT (read/write/response) and LT requests into 10-bit framed
// symbols {stop=1, byte, start=0}. Each symbol is held for SYM_CYCLES clocks.
// Every output except req_ready is registered and is computed from the next
// state, so it changes on the same edge that enters a state.
module sb_trans_gen_param #(
  parameter int MAX_LEN    = 8,
  parameter int SYM_CYCLES = 10
) (
  input  logic                 sb_clk,
  input  logic                 rst,
  input  logic                 disconnect_sbtx,
  input  logic                 tdisconnect_tx_min,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_type,
  input  logic [7:0]           req_addr,
  input  logic [6:0]           req_len,
  input  logic [8*MAX_LEN-1:0] req_data,
  input  logic [15:0]          crc_in,
  output logic [9:0]           trans,
  output logic [1:0]           trans_state,
  output logic                 crc_en,
  output logic                 crc_sel,
  output logic                 trans_sent,
  output logic                 req_err,
  output logic                 disconnected_s
);

  typedef enum logic [3:0] {
    S_DISCONNECT, S_IDLE, S_DLE1, S_STX, S_ADDR, S_LEN, S_DATA,
    S_CRC_H, S_CRC_L, S_DLE2, S_ETX, S_LSE, S_CLSE
  } state_e;

  localparam int             CW        = $clog2(SYM_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SYM_CYCLES - 1);
  localparam logic [6:0]     MAX_LEN_L = 7'(MAX_LEN);

  localparam logic [1:0] T_READ  = 2'd0;
  localparam logic [1:0] T_WRITE = 2'd1;
  localparam logic [1:0] T_RESP  = 2'd2;
  localparam logic [1:0] T_LT    = 2'd3;

  localparam logic [1:0] TS_DISC = 2'd0;
  localparam logic [1:0] TS_IDLE = 2'd1;
  localparam logic [1:0] TS_BUSY = 2'd2;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [6:0]           idx_q, idx_d;
  logic [1:0]           type_q;
  logic [7:0]           addr_q;
  logic [6:0]           len_q;
  logic [8*MAX_LEN-1:0] data_q;
  logic [15:0]          crc_q, crc_d;
  logic                 capture;
  logic                 last;

  logic [7:0]           byte_d;
  logic [9:0]           trans_q, trans_d;
  logic [1:0]           trans_state_q, trans_state_d;
  logic                 crc_en_q, crc_en_d;
  logic                 crc_sel_q, crc_sel_d;
  logic                 trans_sent_q, trans_sent_d;
  logic                 req_err_q, req_err_d;
  logic                 disconnected_q;

  assign last      = (cnt_q == CNT_LAST);
  assign req_ready = (state_q == S_IDLE) && !disconnect_sbtx;

  // Next-state, symbol/byte counters, request capture and CRC latch.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    crc_d        = crc_q;
    capture      = 1'b0;
    req_err_d    = 1'b0;
    trans_sent_d = 1'b0;

    case (state_q)
      S_DISCONNECT: if (!disconnect_sbtx && tdisconnect_tx_min) state_d = S_IDLE;
      S_IDLE: begin
        if (req_valid && req_ready) begin
          if (req_type != T_LT && req_len > MAX_LEN_L) begin
            req_err_d = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = S_DLE1;
          end
        end
      end
      S_DLE1:  if (last) state_d = (type_q == T_LT) ? S_LSE : S_STX;
      S_STX:   if (last) state_d = S_ADDR;
      S_ADDR:  if (last) state_d = S_LEN;
      S_LEN: begin
        if (last) begin
          if (type_q == T_READ || len_q == 7'd0) begin
            state_d = S_CRC_H;
          end else begin
            state_d = S_DATA;
            idx_d   = 7'd0;
          end
        end
      end
      S_DATA: begin
        if (last) begin
          if (idx_q == len_q - 7'd1) state_d = S_CRC_H;
          else                       idx_d   = idx_q + 7'd1;
        end
      end
      S_CRC_H: if (last) state_d = S_CRC_L;
      S_CRC_L: if (last) state_d = S_DLE2;
      S_DLE2:  if (last) state_d = S_ETX;
      S_ETX, S_CLSE: begin
        if (last) begin
          state_d      = S_IDLE;
          trans_sent_d = 1'b1;
        end
      end
      S_LSE:   if (last) state_d = S_CLSE;
      default: state_d = S_DISCONNECT;
    endcase

    // Disconnect overrides everything, including an in-flight transaction.
    if (disconnect_sbtx) begin
      state_d      = S_DISCONNECT;
      capture      = 1'b0;
      req_err_d    = 1'b0;
      trans_sent_d = 1'b0;
    end

    if (state_d == S_CRC_H && state_q != S_CRC_H) crc_d = crc_in;

    // Symbol counter wraps each symbol and restarts on every state change.
    cnt_d = '0;
    if (state_d == state_q && state_q != S_IDLE && state_q != S_DISCONNECT && !last)
      cnt_d = cnt_q + 1'b1;
  end

  // Output values for the state being entered.
  always_comb begin
    byte_d = 8'h00;
    case (state_d)
      S_DLE1, S_DLE2: byte_d = 8'hFE;
      S_STX:          byte_d = (type_q == T_RESP) ? 8'h04 : 8'h05;
      S_ADDR, S_LSE:  byte_d = addr_q;
      S_LEN:          byte_d = {len_q, (type_q == T_WRITE)};
      S_DATA:         byte_d = data_q[{idx_d, 3'b000} +: 8];
      S_CRC_H:        byte_d = crc_d[15:8];
      S_CRC_L:        byte_d = crc_q[7:0];
      S_ETX:          byte_d = 8'h40;
      S_CLSE:         byte_d = ~addr_q;
      default:        byte_d = 8'h00;
    endcase

    trans_d       = {1'b1, byte_d, 1'b0};
    trans_state_d = TS_BUSY;
    if (state_d == S_DISCONNECT) begin
      trans_d       = 10'h000;
      trans_state_d = TS_DISC;
    end else if (state_d == S_IDLE) begin
      trans_d       = 10'h3FF;
      trans_state_d = TS_IDLE;
    end

    crc_en_d  = (state_d inside {S_STX, S_ADDR, S_LEN, S_DATA});
    crc_sel_d = (state_d inside {S_CRC_H, S_CRC_L});
  end

  // State, counters, captured request and registered outputs.
  always_ff @(posedge sb_clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q        <= S_DISCONNECT;
      cnt_q          <= '0;
      idx_q          <= '0;
      type_q         <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      data_q         <= '0;
      crc_q          <= '0;
      trans_q        <= 10'h000;
      trans_state_q  <= TS_DISC;
      crc_en_q       <= 1'b0;
      crc_sel_q      <= 1'b0;
      trans_sent_q   <= 1'b0;
      req_err_q      <= 1'b0;
      disconnected_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      crc_q          <= crc_d;
      trans_q        <= trans_d;
      trans_state_q  <= trans_state_d;
      crc_en_q       <= crc_en_d;
      crc_sel_q      <= crc_sel_d;
      trans_sent_q   <= trans_sent_d;
      req_err_q      <= req_err_d;
      disconnected_q <= (state_d == S_DISCONNECT);
      if (capture) begin
        type_q <= req_type;
        addr_q <= req_addr;
        len_q  <= req_len;
        data_q <= req_data;
      end
    end
  end

  assign trans          = trans_q;
  assign trans_state    = trans_state_q;
  assign crc_en         = crc_en_q;
  assign crc_sel        = crc_sel_q;
  assign trans_sent     = trans_sent_q;
  assign req_err        = req_err_q;
  assign disconnected_s = disconnected_q;

endmodule

// File: tb/tb_sb_trans_gen_param.sv
// Testbench for sb_trans_gen_param: directed and randomized frames checked
// against a symbol-list model built from the frame format rules.
module tb_sb_trans_gen_param;

  localparam int MAX_LEN = 8;
  localparam int SYM     = 10;

  logic                 sb_clk;
  logic                 rst;
  logic                 disconnect_sbtx;
  logic                 tdisconnect_tx_min;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_type;
  logic [7:0]           req_addr;
  logic [6:0]           req_len;
  logic [8*MAX_LEN-1:0] req_data;
  logic [15:0]          crc_in;
  logic [9:0]           trans;
  logic [1:0]           trans_state;
  logic                 crc_en;
  logic                 crc_sel;
  logic                 trans_sent;
  logic                 req_err;
  logic                 disconnected_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] b;
    logic       en;
    logic       sel;
    logic       crc_lo;
  } sym_t;

  sym_t exp_q[$];

  sb_trans_gen_param #(.MAX_LEN(MAX_LEN), .SYM_CYCLES(SYM)) dut (
    .sb_clk             (sb_clk),
    .rst                (rst),
    .disconnect_sbtx    (disconnect_sbtx),
    .tdisconnect_tx_min (tdisconnect_tx_min),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_type           (req_type),
    .req_addr           (req_addr),
    .req_len            (req_len),
    .req_data           (req_data),
    .crc_in             (crc_in),
    .trans              (trans),
    .trans_state        (trans_state),
    .crc_en             (crc_en),
    .crc_sel            (crc_sel),
    .trans_sent         (trans_sent),
    .req_err            (req_err),
    .disconnected_s     (disconnected_s)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

  function automatic sym_t mk(input logic [7:0] b, input logic en, input logic sel,
                              input logic lo);
    sym_t s;
    s.b = b; s.en = en; s.sel = sel; s.crc_lo = lo;
    return s;
  endfunction

  // Expected symbol list for one request, straight from the frame format.
  function automatic void build_frame(input logic [1:0] t, input logic [7:0] a,
                                      input logic [6:0] l,
                                      input logic [8*MAX_LEN-1:0] d,
                                      input logic [15:0] c);
    int nbytes;
    logic [7:0] db;
    exp_q.delete();
    exp_q.push_back(mk(8'hFE, 1'b0, 1'b0, 1'b0));
    if (t == 2'd3) begin
      exp_q.push_back(mk(a, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(~a, 1'b0, 1'b0, 1'b0));
    end else begin
      exp_q.push_back(mk((t == 2'd2) ? 8'h04 : 8'h05, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(a, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk({l, (t == 2'd1)}, 1'b1, 1'b0, 1'b0));
      nbytes = (t == 2'd0) ? 0 : int'(l);
      for (int k = 0; k < nbytes; k++) begin
        db = d[8*k +: 8];
        exp_q.push_back(mk(db, 1'b1, 1'b0, 1'b0));
      end
      exp_q.push_back(mk(c[15:8], 1'b0, 1'b1, 1'b0));
      exp_q.push_back(mk(c[7:0], 1'b0, 1'b1, 1'b1));
      exp_q.push_back(mk(8'hFE, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(8'h40, 1'b0, 1'b0, 1'b0));
    end
  endfunction

  function automatic logic [8*MAX_LEN-1:0] rand_data();
    logic [8*MAX_LEN-1:0] v;
    for (int k = 0; k < MAX_LEN; k++) v[8*k +: 8] = 8'($urandom);
    return v;
  endfunction

  // Issues one legal request at a negedge in IDLE and checks every cycle of
  // the resulting frame, ending on the negedge where trans_sent is high.
  task automatic run_frame(input string tag, input logic [1:0] t, input logic [7:0] a,
                           input logic [6:0] l, input logic [8*MAX_LEN-1:0] d,
                           input logic [15:0] c);
    sym_t s;
    logic [9:0] want;
    build_frame(t, a, l, d, c);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready: got %b want 1", tag, req_ready); end
    req_valid = 1'b1; req_type = t; req_addr = a; req_len = l; req_data = d; crc_in = c;
    @(posedge sb_clk);
    @(negedge sb_clk);
    req_valid = 1'b0;
    req_type  = 2'($urandom); req_addr = 8'($urandom); req_len = 7'($urandom);
    req_data  = rand_data();
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int k = 0; k < SYM; k++) begin
        if (i != 0 || k != 0) @(negedge sb_clk);
        s    = exp_q[i];
        want = {1'b1, s.b, 1'b0};
        n_checks++;
        if (trans !== want) begin n_fail++; $display("FAIL %s trans sym%0d cyc%0d: got %h want %h", tag, i, k, trans, want); end
        n_checks++;
        if (crc_en !== s.en || crc_sel !== s.sel) begin n_fail++; $display("FAIL %s crc_flags sym%0d: got en=%b sel=%b want en=%b sel=%b", tag, i, crc_en, crc_sel, s.en, s.sel); end
        n_checks++;
        if (trans_state !== 2'd2 || trans_sent !== 1'b0) begin n_fail++; $display("FAIL %s busy sym%0d: got state=%0d sent=%b want 2/0", tag, i, trans_state, trans_sent); end
        // CRC must already be latched; disturb the engine output.
        if (s.crc_lo && k == 0) crc_in = ~c;
      end
    end
    @(negedge sb_clk);
    n_checks++;
    if (trans !== 10'h3FF || trans_state !== 2'd1) begin n_fail++; $display("FAIL %s end_idle: got trans=%h state=%0d want 3ff/1", tag, trans, trans_state); end
    n_checks++;
    if (trans_sent !== 1'b1) begin n_fail++; $display("FAIL %s trans_sent: got %b want 1", tag, trans_sent); end
    crc_in = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; disconnect_sbtx = 1'b0; tdisconnect_tx_min = 1'b0; req_valid = 1'b0;
    req_type = '0; req_addr = '0; req_len = '0; req_data = '0; crc_in = '0;
    repeat (2) @(negedge sb_clk);
    n_checks++;
    if (trans !== 10'h000 || trans_state !== 2'd0 || disconnected_s !== 1'b1) begin n_fail++; $display("FAIL reset_state: got trans=%h state=%0d disc=%b want 000/0/1", trans, trans_state, disconnected_s); end
    n_checks++;
    if (crc_en !== 1'b0 || crc_sel !== 1'b0 || trans_sent !== 1'b0 || req_err !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got en=%b sel=%b sent=%b err=%b rdy=%b want all 0", crc_en, crc_sel, trans_sent, req_err, req_ready); end
    rst = 1'b0;
    @(negedge sb_clk);
    n_checks++;
    if (disconnected_s !== 1'b1 || trans !== 10'h000) begin n_fail++; $display("FAIL wait_tmin: got disc=%b trans=%h want 1/000", disconnected_s, trans); end
    disconnect_sbtx = 1'b1; tdisconnect_tx_min = 1'b1;
    @(negedge sb_clk);
    n_checks++;
    if (disconnected_s !== 1'b1) begin n_fail++; $display("FAIL hold_disc: got disc=%b want 1", disconnected_s); end
    disconnect_sbtx = 1'b0;
    @(negedge sb_clk);
    n_checks++;
    if (trans !== 10'h3FF || trans_state !== 2'd1 || disconnected_s !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL to_idle: got trans=%h state=%0d disc=%b rdy=%b want 3ff/1/0/1", trans, trans_state, disconnected_s, req_ready); end
  endtask

  task automatic test_at_read();
    run_frame("at_read", 2'd0, 8'h4E, 7'd3, rand_data(), 16'hA1B2);
  endtask

  task automatic test_at_write();
    logic [8*MAX_LEN-1:0] d;
    d = rand_data();
    d[15:0] = 16'h3344;
    run_frame("at_write", 2'd1, 8'($urandom), 7'd2, d, 16'($urandom));
  endtask

  task automatic test_lt();
    run_frame("lt", 2'd3, 8'h80, 7'($urandom), rand_data(), 16'($urandom));
  endtask

  task automatic test_response_max();
    run_frame("resp_max", 2'd2, 8'($urandom), 7'(MAX_LEN), rand_data(), 16'($urandom));
  endtask

  task automatic test_len_error();
    logic [1:0] bad_t [2];
    logic [6:0] bad_l [2];
    bad_t[0] = 2'd2; bad_l[0] = 7'(MAX_LEN + 1);
    bad_t[1] = 2'd0; bad_l[1] = 7'd127;
    @(negedge sb_clk);
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_type = bad_t[i]; req_len = bad_l[i];
      @(posedge sb_clk);
      @(negedge sb_clk);
      req_valid = 1'b0;
      n_checks++;
      if (req_err !== 1'b1) begin n_fail++; $display("FAIL len_err%0d pulse: got %b want 1", i, req_err); end
      n_checks++;
      if (trans !== 10'h3FF || trans_state !== 2'd1) begin n_fail++; $display("FAIL len_err%0d idle: got trans=%h state=%0d want 3ff/1", i, trans, trans_state); end
      @(negedge sb_clk);
      n_checks++;
      if (req_err !== 1'b0 || trans !== 10'h3FF) begin n_fail++; $display("FAIL len_err%0d after: got err=%b trans=%h want 0/3ff", i, req_err, trans); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_frame($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), 8'($urandom),
                7'($urandom_range(0, MAX_LEN)), rand_data(), 16'($urandom));
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_a", 2'd1, 8'($urandom), 7'd1, rand_data(), 16'($urandom));
    run_frame("b2b_b", 2'd3, 8'($urandom), 7'd0, rand_data(), 16'($urandom));
    run_frame("b2b_c", 2'd2, 8'($urandom), 7'd0, rand_data(), 16'($urandom));
  endtask

  task automatic test_disconnect();
    logic [8*MAX_LEN-1:0] d;
    d = rand_data();
    req_valid = 1'b1; req_type = 2'd1; req_addr = 8'h11; req_len = 7'd4; req_data = d;
    @(posedge sb_clk);
    @(negedge sb_clk);
    req_valid = 1'b0;
    repeat (4 * SYM + 2) @(negedge sb_clk);
    n_checks++;
    if (trans !== {1'b1, d[7:0], 1'b0}) begin n_fail++; $display("FAIL disc_in_data: got %h want %h", trans, {1'b1, d[7:0], 1'b0}); end
    disconnect_sbtx = 1'b1; tdisconnect_tx_min = 1'b0; req_valid = 1'b1; req_type = 2'd3;
    @(negedge sb_clk);
    n_checks++;
    if (trans !== 10'h000 || disconnected_s !== 1'b1 || trans_state !== 2'd0) begin n_fail++; $display("FAIL disc_enter: got trans=%h disc=%b state=%0d want 000/1/0", trans, disconnected_s, trans_state); end
    n_checks++;
    if (trans_sent !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL disc_flags: got sent=%b rdy=%b want 0/0", trans_sent, req_ready); end
    tdisconnect_tx_min = 1'b1;
    @(negedge sb_clk);
    disconnect_sbtx = 1'b0; req_valid = 1'b0;
    @(negedge sb_clk);
    n_checks++;
    if (trans !== 10'h3FF || trans_state !== 2'd1 || disconnected_s !== 1'b0) begin n_fail++; $display("FAIL disc_exit: got trans=%h state=%0d disc=%b want 3ff/1/0", trans, trans_state, disconnected_s); end
    for (int i = 0; i < 2 * SYM; i++) begin
      @(negedge sb_clk);
      n_checks++;
      if (trans_sent !== 1'b0 || trans !== 10'h3FF) begin n_fail++; $display("FAIL disc_quiet cyc%0d: got sent=%b trans=%h want 0/3ff", i, trans_sent, trans); end
    end
    // Request and disconnect on the same edge in IDLE: request must be ignored.
    req_valid = 1'b1; req_type = 2'd3; req_addr = 8'h5A; disconnect_sbtx = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL disc_ready: got %b want 0", req_ready); end
    @(negedge sb_clk);
    n_checks++;
    if (trans !== 10'h000) begin n_fail++; $display("FAIL disc_idle_req: got %h want 000", trans); end
    disconnect_sbtx = 1'b0; req_valid = 1'b0;
    @(negedge sb_clk);
    n_checks++;
    if (trans !== 10'h3FF) begin n_fail++; $display("FAIL disc_no_accept: got %h want 3ff", trans); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_type = 2'd0; req_addr = 8'h22; req_len = 7'd0;
    @(posedge sb_clk);
    @(negedge sb_clk);
    req_valid = 1'b0;
    repeat (15) @(negedge sb_clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (trans !== 10'h000 || trans_state !== 2'd0 || disconnected_s !== 1'b1 || crc_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got trans=%h state=%0d disc=%b en=%b want 000/0/1/0", trans, trans_state, disconnected_s, crc_en); end
    @(negedge sb_clk);
    rst = 1'b0;
    @(negedge sb_clk);
    n_checks++;
    if (trans !== 10'h3FF || trans_sent !== 1'b0) begin n_fail++; $display("FAIL rst_mid_exit: got trans=%h sent=%b want 3ff/0", trans, trans_sent); end
  endtask

  initial begin
    test_reset();
    test_at_read();
    test_at_write();
    test_lt();
    test_response_max();
    test_len_error();
    test_random();
    test_back_to_back();
    test_disconnect();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
